filter_rx_pkt_fifo: RTL and testbench

FILTER_RX_PKT_FIFO -- requirements
Module: filter_rx_pkt_fifo

---
 rtl/filter_rx_pkt_fifo.sv | 173 +++++++++++++++++
 tb/tb_filter_rx_pkt_fifo.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_rx_pkt_fifo.sv
// Store-and-forward packet FIFO: buffers whole packets from the RX filter and releases
// only committed packets to QDMA C2H; a packet that does not fit is tail-dropped.
module filter_rx_pkt_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    input  logic [511:0]             s_axis_tdata,
    input  logic [63:0]              s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [47:0]              s_axis_tuser,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [511:0]             m_axis_tdata,
    output logic [63:0]              m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [47:0]              m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic [31:0]              pkt_in_count,
    output logic [31:0]              pkt_out_count,
    output logic [31:0]              pkt_drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = 625;

    typedef enum logic {
        ACCEPT,
        DROP
    } wr_state_t;

    logic [BW-1:0] mem [DEPTH];

    wr_state_t     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [31:0]   in_cnt_q, in_cnt_d;
    logic [31:0]   out_cnt_q, out_cnt_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;
    logic          mem_valid_q, mem_valid_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] mem_data_q;
    logic [BW-1:0] out_data_q;

    logic          s_beat;
    logic          m_hs;
    logic          out_load;
    logic          rd_en;
    logic          wr_en;
    logic [PW-1:0] free_space;

    assign s_axis_tready = aresetn;
    assign s_beat        = s_axis_tvalid & aresetn;
    assign m_hs          = out_valid_q & m_axis_tready;

    // rd_ptr only moves on the output handshake, so beats held in the read pipeline
    // still occupy their RAM slots; fetch_ptr tracks what has been pulled from RAM.
    assign out_load = mem_valid_q & (~out_valid_q | m_axis_tready);
    assign rd_en    = (fetch_ptr_q != commit_ptr_q) & (~mem_valid_q | out_load);

    assign rd_ptr_d   = rd_ptr_q + PW'(m_hs);
    assign free_space = PW'(DEPTH) - (wr_ptr_q - rd_ptr_d);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        in_cnt_d     = in_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        wr_en        = 1'b0;
        if (s_beat) begin
            case (state_q)
                ACCEPT: begin
                    if (free_space != '0) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_axis_tlast) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            in_cnt_d     = in_cnt_q + 32'd1;
                        end
                    end else begin
                        wr_ptr_d   = commit_ptr_q;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        if (!s_axis_tlast) begin
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_d = ACCEPT;
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_comb begin
        fetch_ptr_d = fetch_ptr_q + PW'(rd_en);
        out_cnt_d   = out_cnt_q;
        if (m_hs && out_data_q[576]) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end
        mem_valid_d = mem_valid_q;
        if (rd_en) begin
            mem_valid_d = 1'b1;
        end else if (out_load) begin
            mem_valid_d = 1'b0;
        end
        out_valid_d = out_valid_q;
        if (out_load) begin
            out_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            mem_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            mem_valid_q  <= mem_valid_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Write and fetch never hit the same slot: fetch stays below commit_ptr <= wr_ptr.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (rd_en) begin
            mem_data_q <= mem[fetch_ptr_q[AW-1:0]];
        end
        if (out_load) begin
            out_data_q <= mem_data_q;
        end
    end

    assign m_axis_tvalid  = out_valid_q;
    assign m_axis_tdata   = out_data_q[511:0];
    assign m_axis_tkeep   = out_data_q[575:512];
    assign m_axis_tlast   = out_data_q[576];
    assign m_axis_tuser   = out_data_q[624:577];
    assign pkt_in_count   = in_cnt_q;
    assign pkt_out_count  = out_cnt_q;
    assign pkt_drop_count = drop_cnt_q;
    assign fill_level     = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_filter_rx_pkt_fifo.sv
// Self-checking bench for filter_rx_pkt_fifo: directed vector table, corner sequences and
// randomized traffic checked against a queue-based packet model.
module tb_filter_rx_pkt_fifo;

    localparam int DEPTH = 64;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s_axis_tvalid;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic [47:0]  s_axis_tuser;
    logic         s_axis_tready;
    logic         m_axis_tvalid;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [47:0]  m_axis_tuser;
    logic         m_axis_tready;
    logic [31:0]  pkt_in_count;
    logic [31:0]  pkt_out_count;
    logic [31:0]  pkt_drop_count;
    logic [6:0]   fill_level;

    filter_rx_pkt_fifo #(.DEPTH(DEPTH)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tready  (m_axis_tready),
        .pkt_in_count   (pkt_in_count),
        .pkt_out_count  (pkt_out_count),
        .pkt_drop_count (pkt_drop_count),
        .fill_level     (fill_level)
    );

    always #5 aclk = ~aclk;

    typedef logic [624:0] beat_t;

    typedef struct {
        int npkt;
        int len;
        int last_len;
        bit ready;
        int exp_in;
        int exp_out;
        int exp_drop;
        int exp_fill;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t part_q[$];
    int    occ = 0;
    int    m_in = 0;
    int    m_out = 0;
    int    m_drop = 0;
    bit    dropping = 1'b0;
    bit    prev_hold = 1'b0;
    bit    rand_ready = 1'b0;
    beat_t prev_payload;

    function automatic beat_t out_beat();
        return {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    endfunction

    function automatic beat_t in_beat();
        return {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    endfunction

    // Packet-level model: occupancy counts beats written and not yet handed out,
    // and a read in the same cycle frees its slot before the write is judged.
    function automatic void model_step();
        beat_t act;
        beat_t e;
        if (!aresetn) begin
            exp_q.delete();
            part_q.delete();
            occ       = 0;
            m_in      = 0;
            m_out     = 0;
            m_drop    = 0;
            dropping  = 1'b0;
            prev_hold = 1'b0;
            return;
        end
        act = out_beat();
        if (prev_hold) begin
            n_vec++;
            if (!m_axis_tvalid || act !== prev_payload) begin
                n_err++;
                $display("FAIL hold: valid=%0b, beat changed while stalled (required stable)", m_axis_tvalid);
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_beat: got %h, required no beat", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL out_beat: got %h required %h", act, e);
                end
            end
            occ--;
            if (m_axis_tlast) m_out++;
        end
        prev_hold    = m_axis_tvalid && !m_axis_tready;
        prev_payload = act;
        if (s_axis_tvalid) begin
            if (dropping) begin
                if (s_axis_tlast) dropping = 1'b0;
            end else if (occ < DEPTH) begin
                part_q.push_back(in_beat());
                occ++;
                if (s_axis_tlast) begin
                    foreach (part_q[k]) exp_q.push_back(part_q[k]);
                    part_q.delete();
                    m_in++;
                end
            end else begin
                occ -= part_q.size();
                part_q.delete();
                m_drop++;
                dropping = !s_axis_tlast;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        model_step();
        @(posedge aclk);
        #1;
        if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic send_beat(input bit last);
        for (int i = 0; i < 16; i++) s_axis_tdata[i*32 +: 32] = $urandom;
        s_axis_tkeep  = {$urandom, $urandom};
        s_axis_tuser  = {16'($urandom), $urandom};
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        tick();
    endtask

    task automatic send_pkt(input int len, input bit bubbles);
        for (int b = 0; b < len; b++) begin
            if (bubbles) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_axis_tvalid = 1'b0;
                    tick();
                end
            end
            send_beat(b == len - 1);
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [7];
        int   len;
        int   guard;
        int   stored;

        vt[0] = '{1,  3,  3,  1'b1, 1,  1,  0, 0};
        vt[1] = '{22, 3,  3,  1'b0, 21, 0,  1, 63};
        vt[2] = '{2,  65, 1,  1'b1, 1,  1,  1, 0};
        vt[3] = '{4,  16, 16, 1'b0, 4,  0,  0, 64};
        vt[4] = '{5,  16, 16, 1'b0, 4,  0,  1, 64};
        vt[5] = '{3,  64, 64, 1'b1, 2,  2,  1, 0};
        vt[6] = '{40, 1,  1,  1'b1, 40, 40, 0, 0};

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_in", 64'(pkt_in_count), 64'd0);
        chk("rst_out", 64'(pkt_out_count), 64'd0);
        chk("rst_drop", 64'(pkt_drop_count), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd1);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            m_axis_tready = vt[i].ready;
            for (int p = 0; p < vt[i].npkt; p++) begin
                send_pkt((p == vt[i].npkt - 1) ? vt[i].last_len : vt[i].len, 1'b0);
            end
            idle(150);
            chk($sformatf("v%0d_in", i), 64'(pkt_in_count), 64'(vt[i].exp_in));
            chk($sformatf("v%0d_out", i), 64'(pkt_out_count), 64'(vt[i].exp_out));
            chk($sformatf("v%0d_drop", i), 64'(pkt_drop_count), 64'(vt[i].exp_drop));
            chk($sformatf("v%0d_fill", i), 64'(fill_level), 64'(vt[i].exp_fill));
            m_axis_tready = 1'b1;
            idle(150);
            chk($sformatf("v%0d_drain_out", i), 64'(pkt_out_count), 64'(vt[i].exp_in));
            chk($sformatf("v%0d_drain_fill", i), 64'(fill_level), 64'd0);
            chk($sformatf("v%0d_leftover", i), 64'(exp_q.size()), 64'd0);
        end

        // Latency: tlast at edge N, first beat visible after edge N+2
        do_reset();
        m_axis_tready = 1'b1;
        send_beat(1'b0);
        send_beat(1'b0);
        send_beat(1'b1);
        s_axis_tvalid = 1'b0;
        chk("lat_n0_valid", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("lat_n1_valid", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("lat_n2_valid", 64'(m_axis_tvalid), 64'd1);
        chk("lat_n2_last", 64'(m_axis_tlast), 64'd0);
        tick();
        tick();
        chk("lat_n4_last", 64'(m_axis_tvalid && m_axis_tlast), 64'd1);
        tick();
        chk("lat_n5_valid", 64'(m_axis_tvalid), 64'd0);
        chk("lat_in", 64'(pkt_in_count), 64'd1);
        chk("lat_out", 64'(pkt_out_count), 64'd1);

        // Exactly full, then a tlast write coinciding with a read
        do_reset();
        m_axis_tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(16, 1'b0);
        idle(5);
        chk("full_fill", 64'(fill_level), 64'd64);
        m_axis_tready = 1'b1;
        send_beat(1'b1);
        s_axis_tvalid = 1'b0;
        chk("full_rw_drop", 64'(pkt_drop_count), 64'd0);
        chk("full_rw_in", 64'(pkt_in_count), 64'd5);
        chk("full_rw_fill", 64'(fill_level), 64'd64);
        idle(150);
        chk("full_rw_out", 64'(pkt_out_count), 64'd5);
        chk("full_rw_leftover", 64'(exp_q.size()), 64'd0);

        // Reset mid-packet with two packets stored
        do_reset();
        m_axis_tready = 1'b0;
        send_pkt(4, 1'b0);
        send_pkt(4, 1'b0);
        send_beat(1'b0);
        send_beat(1'b0);
        chk("mid_pre_in", 64'(pkt_in_count), 64'd2);
        chk("mid_pre_fill", 64'(fill_level), 64'd10);
        aresetn = 1'b0;
        #1;
        chk("mid_s_tready", 64'(s_axis_tready), 64'd0);
        tick();
        chk("mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_in", 64'(pkt_in_count), 64'd0);
        chk("mid_out", 64'(pkt_out_count), 64'd0);
        chk("mid_drop", 64'(pkt_drop_count), 64'd0);
        chk("mid_fill", 64'(fill_level), 64'd0);
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        send_pkt(3, 1'b0);
        idle(20);
        chk("mid_post_in", 64'(pkt_in_count), 64'd1);
        chk("mid_post_out", 64'(pkt_out_count), 64'd1);
        chk("mid_post_leftover", 64'(exp_q.size()), 64'd0);

        // Randomized traffic with 50% downstream ready, throttled so nothing overflows
        do_reset();
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len   = $urandom_range(1, 20);
            guard = 0;
            while (occ + len > DEPTH && guard < 2000) begin
                tick();
                guard++;
            end
            if (guard >= 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL rand_throttle: occupancy %0d stuck, required drain below %0d", occ, DEPTH - len);
                break;
            end
            send_pkt(len, 1'b1);
        end
        stored = 0;
        foreach (exp_q[k]) if (exp_q[k][576]) stored++;
        chk("rand_in_rel", 64'(pkt_in_count), 64'(m_out + stored));
        chk("rand_drop_mid", 64'(pkt_drop_count), 64'd0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            tick();
            guard++;
        end
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        idle(5);
        chk("rand_leftover", 64'(exp_q.size()), 64'd0);
        chk("rand_in", 64'(pkt_in_count), 64'd1000);
        chk("rand_out", 64'(pkt_out_count), 64'd1000);
        chk("rand_drop", 64'(pkt_drop_count), 64'd0);
        chk("rand_fill", 64'(fill_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
